// File: rtl/target_pc_queue_if.sv
// Fetch-side bundle of the target PC queue: ID-stage target, stall and
// resolve-stage mispredict in, PC/valid/redirect/busy toward fetch out.
interface target_pc_queue_if #(
    parameter int XLEN = 32
);
    logic            stall_i;
    logic            id_valid_i;
    logic [XLEN-1:0] id_target_i;
    logic            mispredict_i;
    logic [XLEN-1:0] target_pc_o;
    logic            target_valid_o;
    logic            redirect_o;
    logic            busy_o;

    modport master (
        output stall_i, id_valid_i, id_target_i, mispredict_i,
        input  target_pc_o, target_valid_o, redirect_o, busy_o
    );

    modport slave (
        input  stall_i, id_valid_i, id_target_i, mispredict_i,
        output target_pc_o, target_valid_o, redirect_o, busy_o
    );
endinterface

// File: rtl/target_pc_queue.sv
// Target PC history queue with mispredict recovery redirect and squash window.
// Optional feature macro: TARGET_PC_MISPRED_CNT_EN adds mispred_cnt_o.
module target_pc_queue #(
    parameter int XLEN        = 32,
    parameter int DEPTH       = 2,
    parameter int RESOLVE_IDX = DEPTH - 1,
    parameter int SQUASH      = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    target_pc_queue_if.slave      bus
`ifdef TARGET_PC_MISPRED_CNT_EN
    ,
    output logic [15:0]           mispred_cnt_o
`endif
);

    typedef enum logic {
        IDLE    = 1'b0,
        RECOVER = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_nxt_s;
    logic [3:0]      squash_cnt_r;
    logic [3:0]      squash_cnt_nxt_s;
    logic [XLEN-1:0] hist_r [DEPTH];
    logic [DEPTH-1:0] v_r;
    logic            accept_s;

    assign accept_s = (state_r == IDLE) && bus.mispredict_i && v_r[RESOLVE_IDX];

    // State and squash counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= IDLE;
            squash_cnt_r <= 4'd0;
        end else begin
            state_r      <= state_nxt_s;
            squash_cnt_r <= squash_cnt_nxt_s;
        end
    end

    // Next-state: accepted mispredict opens the squash window, which only counts down while unstalled
    always_comb begin
        state_nxt_s      = state_r;
        squash_cnt_nxt_s = squash_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s      = RECOVER;
                    squash_cnt_nxt_s = 4'(SQUASH);
                end else begin
                    state_nxt_s      = IDLE;
                    squash_cnt_nxt_s = squash_cnt_r;
                end
            end
            RECOVER: begin
                if (!bus.stall_i) begin
                    squash_cnt_nxt_s = squash_cnt_r - 4'd1;
                    if (squash_cnt_r <= 4'd1) begin
                        state_nxt_s = IDLE;
                    end else begin
                        state_nxt_s = RECOVER;
                    end
                end else begin
                    state_nxt_s      = RECOVER;
                    squash_cnt_nxt_s = squash_cnt_r;
                end
            end
            default: begin
                state_nxt_s      = IDLE;
                squash_cnt_nxt_s = 4'd0;
            end
        endcase
    end

    // History shift register; valid bits are wiped on the accept edge even under stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                hist_r[i] <= '0;
            end
            v_r <= '0;
        end else begin
            if (!bus.stall_i) begin
                hist_r[0] <= bus.id_target_i;
                for (int i = 1; i < DEPTH; i++) begin
                    hist_r[i] <= hist_r[i-1];
                end
            end
            if (accept_s) begin
                v_r <= '0;
            end else if (!bus.stall_i) begin
                v_r[0] <= bus.id_valid_i & (state_r == IDLE);
                for (int i = 1; i < DEPTH; i++) begin
                    v_r[i] <= v_r[i-1];
                end
            end
        end
    end

    // Fetch-facing outputs; the redirect must appear in the same cycle as the mispredict
    always_comb begin
        bus.target_pc_o    = '0;
        bus.target_valid_o = 1'b0;
        bus.redirect_o     = 1'b0;
        bus.busy_o         = 1'b0;
        if (!reset) begin
            bus.target_pc_o    = '0;
            bus.target_valid_o = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        bus.target_pc_o    = hist_r[RESOLVE_IDX];
                        bus.target_valid_o = 1'b1;
                        bus.redirect_o     = 1'b1;
                    end else begin
                        bus.target_pc_o    = bus.id_target_i;
                        bus.target_valid_o = bus.id_valid_i;
                        bus.redirect_o     = 1'b0;
                    end
                end
                RECOVER: begin
                    bus.busy_o = 1'b1;
                end
                default: begin
                    bus.busy_o = 1'b0;
                end
            endcase
        end
    end

`ifdef TARGET_PC_MISPRED_CNT_EN
    logic [15:0] mispred_cnt_r;

    // Saturating count of accepted mispredictions
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mispred_cnt_r <= 16'd0;
        end else if (accept_s && (mispred_cnt_r != 16'hFFFF)) begin
            mispred_cnt_r <= mispred_cnt_r + 16'd1;
        end
    end

    assign mispred_cnt_o = mispred_cnt_r;
`endif

endmodule

// File: doc/target_pc_queue.md
TARGET_PC_QUEUE -- requirements
Module: target_pc_queue

Interface
REQ-001 Parameter XLEN, default 32, width of every target PC.
REQ-002 Parameter DEPTH, default 2, number of history entries (legal 1..8).
REQ-003 Parameter RESOLVE_IDX, default DEPTH-1, history entry used on misprediction (legal 0..DEPTH-1).
REQ-004 Parameter SQUASH, default 1, cycles of wrong-path suppression after redirect (legal 1..15).
REQ-005 clk  input  1  clock, all state updates on rising edge.
REQ-006 reset  input  1  reset, asynchronous, active-low.
REQ-007 stall_i  input  1  pipeline stall, freezes history and squash counter.
REQ-008 id_valid_i  input  1  ID-stage target is a real branch/jump target.
REQ-009 id_target_i  input  XLEN  target PC computed in ID.
REQ-010 mispredict_i  input  1  branch at resolve stage mispredicted.
REQ-011 target_pc_o  output  XLEN  PC delivered to fetch.
REQ-012 target_valid_o  output  1  target_pc_o is meaningful.
REQ-013 redirect_o  output  1  target_pc_o is a recovery redirect.
REQ-014 busy_o  output  1  block in RECOVER state.

Function
REQ-015 History SHALL be DEPTH entries hist[i] (XLEN) each with valid bit v[i].
REQ-016 Each edge with stall_i=0: hist[0]<=id_target_i, v[0]<=id_valid_i & (state==IDLE); hist[i]<=hist[i-1], v[i]<=v[i-1] for i>=1.
REQ-017 Each edge with stall_i=1: history and valid bits hold, except REQ-020 clearing.
REQ-018 Misprediction accepted when mispredict_i=1, state==IDLE and v[RESOLVE_IDX]=1; otherwise ignored with no state change.
REQ-019 Accepted misprediction: same cycle, combinationally, target_pc_o=hist[RESOLVE_IDX], target_valid_o=1, redirect_o=1.
REQ-020 Edge after accepted misprediction: all v[i] cleared regardless of stall_i, state->RECOVER, squash counter loaded with SQUASH.
REQ-021 IDLE without accepted misprediction: target_pc_o=id_target_i, target_valid_o=id_valid_i, redirect_o=0.
REQ-022 RECOVER: target_pc_o=0, target_valid_o=0, redirect_o=0, busy_o=1; id_valid_i squashed (enters history invalid); mispredict_i ignored.
REQ-023 RECOVER: counter decrements on each edge with stall_i=0, holds when stall_i=1; edge at which counter equals 1 returns state to IDLE.
REQ-024 FSM has exactly two states, IDLE and RECOVER; busy_o=1 only in RECOVER.
REQ-025 Simultaneous mispredict_i and stall_i in IDLE: redirect still issued, REQ-020 applies, counter starts decrementing only once stall_i=0.
REQ-026 DEPTH=1, RESOLVE_IDX=0 SHALL be supported (single-entry history).

Reset
REQ-027 reset low SHALL asynchronously clear all hist[i] to 0, all v[i] to 0, counter to 0, state to IDLE.
REQ-028 While reset low: target_pc_o=0, target_valid_o=0, redirect_o=0, busy_o=0, independent of inputs.
REQ-029 reset asserted mid-RECOVER aborts recovery; first edge after release behaves as IDLE.

Configuration
REQ-030 Macro TARGET_PC_MISPRED_CNT_EN defined: adds output mispred_cnt_o (16 bits), increments on each accepted misprediction, saturates at 16'hFFFF, cleared by reset.
REQ-031 Macro undefined: mispred_cnt_o port and counter absent; all other behaviour identical.

Verification
REQ-032 Reset low, id_target_i=32'h100, id_valid_i=1 -> target_pc_o=0, target_valid_o=0, busy_o=0.
REQ-033 DEPTH=2: push 32'h100, 32'h200, 32'h300 valid on three edges, then mispredict_i=1 -> target_pc_o=32'h200, redirect_o=1 same cycle; busy_o=1 for exactly SQUASH=1 cycle.
REQ-034 Mispredict_i=1 with v[RESOLVE_IDX]=0 (after reset, one push) -> target_pc_o=id_target_i, redirect_o=0, busy_o stays 0.
REQ-035 SQUASH=3, stall_i=1 for 2 cycles during RECOVER -> busy_o=1 for 5 cycles; id_valid_i pushed during RECOVER never later redirects.
REQ-036 reset pulsed low during RECOVER -> busy_o=0 immediately, history invalid, next valid push accepted normally.
REQ-037 With TARGET_PC_MISPRED_CNT_EN: 3 accepted and 2 ignored mispredictions -> mispred_cnt_o=3; counter preset near 16'hFFFF saturates.
